// File: rtl/lane_packer_pkg.sv
// Shared sizing and the packed lane-word type for the lane packer.
package lane_packer_pkg;

    localparam int LANES = 5;
    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    typedef logic [LANES-1:0][WIDTH-1:0] lane_word_t;

endpackage

// File: rtl/lane_packer_pack_out_slot.sv
// Output slot: holds one packed word, 1-cycle load-to-valid latency; a load in the drain cycle wins.
// Contents stay frozen while valid and not ready; clk_en = valid & ready is the crossbar capture strobe.
module pack_out_slot
    import lane_packer_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [LANES*WIDTH-1:0] load_word,
    input  logic [CNT_W-1:0]       load_count,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] word,
    output logic                   out_valid,
    output logic [CNT_W-1:0]       out_count,
    output logic                   clk_en,
    output logic                   free
);

    assign clk_en = out_valid & out_ready;
    assign free   = ~out_valid | clk_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            word      <= '0;
            out_count <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            word      <= load_word;
            out_count <= load_count;
        end else if (clk_en) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/lane_packer.sv
// Byte stream -> 5x8 lane word; io_out_valid one cycle after the 5th byte. Optional LANE_PACKER_FLUSH_EN adds io_flush.
// Only the word-completing byte stalls on a full slot; bytes 1..4 keep flowing into the accumulator.
module lane_packer
    import lane_packer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_in_data,
    input  logic             io_in_valid,
    output logic             io_in_ready,
`ifdef LANE_PACKER_FLUSH_EN
    input  logic             io_flush,
`endif
    output logic [WIDTH-1:0] io_output_0,
    output logic [WIDTH-1:0] io_output_1,
    output logic [WIDTH-1:0] io_output_2,
    output logic [WIDTH-1:0] io_output_3,
    output logic [WIDTH-1:0] io_output_4,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic             io_clk_en,
    output logic [CNT_W-1:0] io_out_count
);

    logic [CNT_W-1:0]              cnt;
    logic [LANES-2:0][WIDTH-1:0]   acc;
    lane_word_t                    next_word;
    lane_word_t                    slot_word;
    logic [CNT_W-1:0]              load_count;
    logic                          in_fire;
    logic                          slot_free;
    logic                          full_load;
    logic                          flush_go;
    logic                          load;

    assign io_in_ready = ~reset & ((cnt < CNT_W'(LANES-1)) | slot_free);
    assign in_fire     = io_in_valid & io_in_ready;
    assign full_load   = in_fire & (cnt == CNT_W'(LANES-1));

`ifdef LANE_PACKER_FLUSH_EN
    assign flush_go = io_flush & ((cnt != '0) | in_fire) & slot_free;
`else
    assign flush_go = 1'b0;
`endif

    assign load       = full_load | flush_go;
    assign load_count = cnt + CNT_W'(in_fire);

    // Stale accumulator lanes above cnt are masked so a flushed word pads with zeros.
    always_comb begin
        next_word = '0;
        for (int i = 0; i < LANES-1; i++) begin
            if (CNT_W'(i) < cnt) next_word[i] = acc[i];
        end
        if (in_fire) next_word[cnt] = io_in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (in_fire) begin
            acc[cnt[1:0]] <= io_in_data;
            cnt           <= cnt + CNT_W'(1);
        end
    end

    pack_out_slot u_slot (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_word  (next_word),
        .load_count (load_count),
        .out_ready  (io_out_ready),
        .word       (slot_word),
        .out_valid  (io_out_valid),
        .out_count  (io_out_count),
        .clk_en     (io_clk_en),
        .free       (slot_free)
    );

    assign io_output_0 = slot_word[0];
    assign io_output_1 = slot_word[1];
    assign io_output_2 = slot_word[2];
    assign io_output_3 = slot_word[3];
    assign io_output_4 = slot_word[4];

endmodule

// File: tb/tb_lane_packer.sv
// Scoreboard bench for lane_packer: byte-queue reference model, monitor pops on every io_clk_en.
module tb_lane_packer;

    logic       clk;
    logic       reset;
    logic [7:0] io_in_data;
    logic       io_in_valid;
    logic       io_in_ready;
    logic [7:0] io_output_0, io_output_1, io_output_2, io_output_3, io_output_4;
    logic       io_out_valid;
    logic       io_out_ready;
    logic       io_clk_en;
    logic [2:0] io_out_count;
`ifdef LANE_PACKER_FLUSH_EN
    logic       io_flush;
`endif

    lane_packer dut (
        .clk          (clk),
        .reset        (reset),
        .io_in_data   (io_in_data),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
`ifdef LANE_PACKER_FLUSH_EN
        .io_flush     (io_flush),
`endif
        .io_output_0  (io_output_0),
        .io_output_1  (io_output_1),
        .io_output_2  (io_output_2),
        .io_output_3  (io_output_3),
        .io_output_4  (io_output_4),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_clk_en    (io_clk_en),
        .io_out_count (io_out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  part[$];
    logic [39:0] expq[$];
    int          cntq[$];
    bit          want_valid = 0;
    bit          hold_prev  = 0;
    bit          last_fire  = 0;
    bit          reset_prev = 0;
    logic [39:0] prev_word;
    logic [2:0]  prev_count;
    int          ready_mode = 0;

    logic [39:0] dut_word;
    assign dut_word = {io_output_4, io_output_3, io_output_2, io_output_1, io_output_0};

    function automatic void check(input bit ok, input string name,
                                  input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Whatever bytes are pending become one expected word, zero-padded.
    function automatic void push_word();
        logic [39:0] w;
        w = '0;
        for (int i = 0; i < part.size(); i++) w[i*8 +: 8] = part[i];
        expq.push_back(w);
        cntq.push_back(part.size());
        part.delete();
        want_valid = 1;
    endfunction

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       io_out_ready = 1'b1;
            1:       io_out_ready = 1'b0;
            default: io_out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        logic        fire;
        logic        exp_rdy;
        logic [39:0] w;
        int          c;
        if (reset) begin
            if (reset_prev) begin
                check(!io_out_valid, "reset_valid", io_out_valid, 0);
                check(dut_word == 0 && io_out_count == 0, "reset_outputs",
                      {io_out_count, dut_word}, 0);
                check(!io_clk_en, "reset_clk_en", io_clk_en, 0);
            end
            check(!io_in_ready, "reset_in_ready", io_in_ready, 0);
            part.delete(); expq.delete(); cntq.delete();
            want_valid = 0; hold_prev = 0; last_fire = 0;
        end else begin
            if (want_valid) check(io_out_valid, "latency", io_out_valid, 1);
            want_valid = 0;
            check(io_clk_en == (io_out_valid & io_out_ready), "clk_en",
                  io_clk_en, io_out_valid & io_out_ready);
            exp_rdy = (part.size() != 4) || !io_out_valid || io_out_ready;
            check(io_in_ready == exp_rdy, "in_ready", io_in_ready, exp_rdy);
            if (hold_prev)
                check(dut_word == prev_word && io_out_count == prev_count, "stable",
                      {io_out_count, dut_word}, {prev_count, prev_word});
            if (io_clk_en) begin
                if (expq.size() == 0) begin
                    check(0, "extra_word", dut_word, 0);
                end else begin
                    w = expq.pop_front();
                    c = cntq.pop_front();
                    check(dut_word == w, "word", dut_word, w);
                    check(io_out_count == 3'(c), "count", io_out_count, c);
                end
            end
            fire = io_in_valid & io_in_ready;
            if (fire) begin
                part.push_back(io_in_data);
                if (part.size() == 5) push_word();
            end
`ifdef LANE_PACKER_FLUSH_EN
            if (io_flush && part.size() > 0 && (!io_out_valid || io_out_ready)) push_word();
`endif
            hold_prev  = io_out_valid & !io_out_ready;
            prev_word  = dut_word;
            prev_count = io_out_count;
            last_fire  = fire;
        end
        reset_prev = reset;
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b, input int gap, input bit imm);
        int n = 0;
        io_in_valid = 1'b1;
        io_in_data  = b;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!last_fire && n < 300);
        if (!last_fire) check(0, "send_timeout", n, 300);
        if (imm) check(n == 1, "no_bubble", n, 1);
        io_in_valid = 1'b0;
        idle(gap);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        io_in_valid = 1'b0;
        io_in_data  = 8'h00;
        io_out_ready = 1'b1;
`ifdef LANE_PACKER_FLUSH_EN
        io_flush = 1'b0;
`endif
        ready_mode = 0;
        idle(3);
        reset = 1'b0;

        // Back-to-back stream with the consumer always ready.
        for (int b = 1; b <= 10; b++) send(8'(b), 0, 1);
        idle(3);

        // Consumer stalled: bytes 6..9 still flow, the 10th waits for the drain.
        ready_mode = 1;
        idle(2);
        for (int b = 1; b <= 9; b++) send(8'(8'h20 + b), 0, 1);
        io_in_valid = 1'b1;
        io_in_data  = 8'h2A;
        repeat (3) begin
            @(negedge clk);
            check(!io_in_ready, "stall_ready", io_in_ready, 0);
            check(io_out_valid && io_output_0 == 8'h21, "stall_hold", io_output_0, 8'h21);
        end
        @(posedge clk); #1;
        ready_mode = 0;
        send(8'h2A, 0, 0);
        idle(4);

        // Reset in the middle of a word discards the partial bytes.
        for (int b = 0; b < 3; b++) send(8'(8'h41 + b), 0, 1);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        for (int b = 0; b < 5; b++) send(8'(8'hA0 + b), 0, 1);
        idle(3);

        // Sparse input, one byte every third cycle.
        for (int b = 0; b < 10; b++) send(8'(8'h60 + b), 2, 1);
        idle(3);

`ifdef LANE_PACKER_FLUSH_EN
        send(8'h11, 0, 1);
        send(8'h22, 0, 1);
        io_flush = 1'b1;
        idle(1);
        io_flush = 1'b0;
        idle(3);
        for (int b = 1; b <= 4; b++) send(8'(8'h30 + b), 0, 1);
        io_flush = 1'b1;
        send(8'h35, 0, 1);
        io_flush = 1'b0;
        idle(4);
        io_flush = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check(!io_out_valid, "flush_empty", io_out_valid, 0);
        end
        @(posedge clk); #1;
        io_flush = 1'b0;
        idle(2);
`endif

        // Random bytes, gaps and consumer backpressure.
        ready_mode = 2;
        for (int k = 0; k < 200; k++)
            send(8'($urandom), $urandom_range(0, 2), 0);
        ready_mode = 0;
        idle(10);
        check(expq.size() == 0, "drain_all", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
